fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 90 +++++++++
 tb/tb_fetch_stage.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register with flush/stall/branch redirect,
// ROM interface and the IF/ID pipeline register with a delivered-instruction counter.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i,
  input  logic [31:0] rom_inst_i,
  output logic [31:0] rom_addr_o,
  output logic        rom_ce_o,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic        id_adel,
  output logic [31:0] fetch_count
);

  logic        r_ce;
  logic [31:0] r_pc;
  logic [31:0] r_id_pc;
  logic [31:0] r_id_inst;
  logic        r_id_adel;
  logic [31:0] r_fetch_count;

  logic [31:0] w_pc_next;
  logic        w_misaligned;
  logic        w_bubble;
  logic        w_capture;
  logic        w_unused;

  // Only the PC, IF/ID and ID/EX stall bits matter to this stage.
  assign w_unused     = ^stall[5:3];
  assign w_misaligned = |r_pc[1:0];

  assign rom_addr_o = r_pc;
  assign rom_ce_o   = r_ce & ~w_misaligned;

  always_comb begin
    // NOTE: default assignment first so every path drives w_pc_next and no latch is inferred.
    w_pc_next = r_pc + 32'd4;
    if (!r_ce)              w_pc_next = RESET_PC;
    else if (flush)         w_pc_next = new_pc;
    else if (stall[0])      w_pc_next = r_pc;
    else if (branch_flag_i) w_pc_next = branch_target_address_i;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ce <= 1'b0;
      r_pc <= RESET_PC;
    end else begin
      r_ce <= 1'b1;
      r_pc <= w_pc_next;
    end
  end

  // A stalled IF/ID with a running ID/EX must inject a bubble, not replay the held entry.
  assign w_bubble  = stall[1] & ~stall[2];
  assign w_capture = rst & ~flush & ~stall[1];

  always_ff @(posedge clk) begin
    if (!rst || flush || w_bubble) begin
      r_id_pc   <= 32'h0;
      r_id_inst <= 32'h0;
      r_id_adel <= 1'b0;
    end else if (!stall[1]) begin
      r_id_pc   <= r_ce ? r_pc : 32'h0;
      r_id_inst <= rom_ce_o ? rom_inst_i : 32'h0;
      r_id_adel <= r_ce & w_misaligned;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)
      r_fetch_count <= 32'h0;
    else if (w_capture && r_ce)
      r_fetch_count <= r_fetch_count + 32'd1;
  end

  assign id_pc       = r_id_pc;
  assign id_inst     = r_id_inst;
  assign id_adel     = r_id_adel;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios with literal pins,
// then randomized traffic compared every cycle against a behavioural model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag_i;
  logic [31:0] branch_target_address_i;
  logic [31:0] rom_inst_i;
  logic [31:0] rom_addr_o;
  logic        rom_ce_o;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_adel;
  logic [31:0] fetch_count;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall                   (stall),
    .flush                   (flush),
    .new_pc                  (new_pc),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .rom_inst_i              (rom_inst_i),
    .rom_addr_o              (rom_addr_o),
    .rom_ce_o                (rom_ce_o),
    .id_pc                   (id_pc),
    .id_inst                 (id_inst),
    .id_adel                 (id_adel),
    .fetch_count             (fetch_count)
  );

  // ROM content: word i holds i+1.
  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    return (addr >> 2) + 32'd1;
  endfunction

  assign rom_inst_i = rom_word(rom_addr_o);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural state of the stage, stepped once per rising edge.
  bit          m_ce;
  logic [31:0] m_pc, m_id_pc, m_id_inst, m_count;
  bit          m_id_adel;

  always @(posedge clk) begin
    bit aligned;
    aligned = (m_pc % 4) == 0;
    if (!rst) begin
      m_ce = 0; m_pc = 32'h0; m_id_pc = 0; m_id_inst = 0; m_id_adel = 0; m_count = 0;
    end else begin
      if (flush || (stall[1] && !stall[2])) begin
        m_id_pc = 0; m_id_inst = 0; m_id_adel = 0;
      end else if (!stall[1]) begin
        if (m_ce) begin
          m_id_pc   = m_pc;
          m_id_inst = aligned ? rom_word(m_pc) : 32'h0;
          m_id_adel = !aligned;
          m_count   = m_count + 1;
        end else begin
          m_id_pc = 0; m_id_inst = 0; m_id_adel = 0;
        end
      end
      if (!m_ce)              m_pc = 32'h0;
      else if (flush)         m_pc = new_pc;
      else if (stall[0])      m_pc = m_pc;
      else if (branch_flag_i) m_pc = branch_target_address_i;
      else                    m_pc = m_pc + 4;
      m_ce = 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("rom_addr_o", rom_addr_o, m_pc);
      check("rom_ce_o", {31'b0, rom_ce_o}, {31'b0, m_ce && (m_pc % 4 == 0)});
      check("id_pc", id_pc, m_id_pc);
      check("id_inst", id_inst, m_id_inst);
      check("id_adel", {31'b0, id_adel}, {31'b0, m_id_adel});
      check("fetch_count", fetch_count, m_count);
    end
  end

  task automatic cyc(input logic r, input logic [5:0] s, input logic f, input logic [31:0] np,
                     input logic b, input logic [31:0] t);
    rst = r; stall = s; flush = f; new_pc = np; branch_flag_i = b; branch_target_address_i = t;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input logic [5:0] s);
    cyc(1'b1, s, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  initial begin
    logic        r, f, b;
    logic [5:0]  s;
    logic [31:0] np, t;

    rst = 1'b0; stall = '0; flush = 1'b0; new_pc = '0; branch_flag_i = 1'b0;
    branch_target_address_i = '0;
    @(negedge clk);

    cyc(1'b0, 6'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    chk_en = 1'b1;
    cyc(1'b0, 6'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    check("pin_reset_rom_ce", {31'b0, rom_ce_o}, 32'h0);
    check("pin_reset_count", fetch_count, 32'h0);

    run(6'h0);
    check("pin_first_edge_id_pc", id_pc, 32'h0);
    check("pin_first_edge_count", fetch_count, 32'h0);
    check("pin_first_edge_rom_ce", {31'b0, rom_ce_o}, 32'h1);
    run(6'h0);
    check("pin_b_id_inst", id_inst, 32'h1);
    check("pin_b_count", fetch_count, 32'h1);
    run(6'h0);
    check("pin_c_id_pc", id_pc, 32'h4);
    check("pin_c_id_inst", id_inst, 32'h2);

    run(6'b000111);
    run(6'b000111);
    check("pin_hold_id_pc", id_pc, 32'h4);
    check("pin_hold_count", fetch_count, 32'h2);
    check("pin_hold_pc", rom_addr_o, 32'h8);
    run(6'h0);
    check("pin_resume_id_pc", id_pc, 32'h8);
    check("pin_resume_count", fetch_count, 32'h3);

    run(6'b000011);
    check("pin_bubble_id_inst", id_inst, 32'h0);
    check("pin_bubble_count", fetch_count, 32'h3);
    run(6'h0);
    check("pin_after_bubble_id_pc", id_pc, 32'hC);

    cyc(1'b1, 6'h0, 1'b1, 32'h0000_000C, 1'b0, 32'h0);
    check("pin_flush_id_pc", id_pc, 32'h0);
    cyc(1'b1, 6'h0, 1'b0, 32'h0, 1'b1, 32'h0000_0100);
    check("pin_delay_slot_id_pc", id_pc, 32'hC);
    check("pin_branch_pc", rom_addr_o, 32'h100);
    run(6'h0);
    check("pin_target_id_pc", id_pc, 32'h100);
    check("pin_target_id_inst", id_inst, 32'h41);
    run(6'h0);
    check("pin_target_plus4", id_pc, 32'h104);

    cyc(1'b1, 6'h0, 1'b0, 32'h0, 1'b1, 32'h0000_0102);
    check("pin_misaligned_rom_ce", {31'b0, rom_ce_o}, 32'h0);
    run(6'h0);
    check("pin_adel", {31'b0, id_adel}, 32'h1);
    check("pin_adel_inst", id_inst, 32'h0);
    check("pin_adel_count", fetch_count, 32'h9);
    cyc(1'b1, 6'h0, 1'b1, 32'h0000_0020, 1'b0, 32'h0);
    check("pin_flush20_adel", {31'b0, id_adel}, 32'h0);
    run(6'h0);
    check("pin_flush20_id_pc", id_pc, 32'h20);

    cyc(1'b1, 6'h0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    run(6'h0);
    check("pin_wrap_pc", rom_addr_o, 32'h0);
    check("pin_wrap_id_inst", id_inst, 32'h4000_0000);
    cyc(1'b1, 6'h0, 1'b1, 32'h0000_0040, 1'b1, 32'h0000_0200);
    check("pin_flush_beats_branch", rom_addr_o, 32'h40);

    cyc(1'b0, 6'h3F, 1'b1, 32'h0000_0080, 1'b1, 32'h0000_0300);
    check("pin_midreset_pc", rom_addr_o, 32'h0);
    check("pin_midreset_count", fetch_count, 32'h0);
    check("pin_midreset_id_pc", id_pc, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 99) != 0);
      s  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'h0;
      f  = ($urandom_range(0, 19) == 0);
      np = $urandom;
      if ($urandom_range(0, 3) != 0) np[1:0] = 2'b00;
      if ($urandom_range(0, 9) == 0) np = 32'hFFFF_FFF8;
      b  = ($urandom_range(0, 5) == 0);
      t  = $urandom;
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      cyc(r, s, f, np, b, t);
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
